// File: rtl/pixel_bridge_pkg.sv
// -----------------------------------------------------------------------------
// pixel_bridge_pkg
// Shared definitions for the pixel readback encoder: bus widths, command
// opcodes, FSM state encoding, status register bit positions and the
// wrap-around address increment helper.
// -----------------------------------------------------------------------------
package pixel_bridge_pkg;

    localparam int ADDR_W = 17;   // pixel address width
    localparam int PIX_W  = 12;   // pixel data width
    localparam int CNT_W  = 8;    // pair count / pair index width

    localparam logic [1:0] OP_READ = 2'b10;

    // Status register bit positions
    localparam int ST_BUSY       = 0;
    localparam int ST_DATA_VALID = 1;
    localparam int ST_DONE       = 2;
    localparam int ST_TIMEOUT    = 3;
    localparam int ST_OVERRUN    = 4;
    localparam int ST_BAD_OP     = 5;
    localparam int ST_REM_LSB    = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2,
        HOLD      = 2'd3
    } state_e;

    // Next pixel address; the last valid address rolls over to zero.
    function automatic logic [ADDR_W-1:0] addr_wrap_inc(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] max_addr
    );
        if (addr == max_addr) begin
            return {ADDR_W{1'b0}};
        end else begin
            return addr + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/pixel_readback_encode_if.sv
// -----------------------------------------------------------------------------
// pixel_readback_encode_if
// Groups the command, pixel-memory and readback signals of the encoder.
//   master : the encoder (drives o_*, receives i_*)
//   slave  : the environment (AXI register side + pixel memory)
// -----------------------------------------------------------------------------
interface pixel_readback_encode_if;
    import pixel_bridge_pkg::*;

    logic [31:0]       i_CMD_REG;
    logic              i_CMD_STROBE;
    logic              o_READ;
    logic [ADDR_W-1:0] o_ADDRESS;
    logic [PIX_W-1:0]  i_DATA;
    logic              i_VALID_RD_DATA;
    logic [31:0]       o_RD_DATA_REG;
    logic [31:0]       o_STATUS_REG;
    logic              i_DATA_ACK;

    modport master (
        input  i_CMD_REG, i_CMD_STROBE, i_DATA, i_VALID_RD_DATA, i_DATA_ACK,
        output o_READ, o_ADDRESS, o_RD_DATA_REG, o_STATUS_REG
    );

    modport slave (
        output i_CMD_REG, i_CMD_STROBE, i_DATA, i_VALID_RD_DATA, i_DATA_ACK,
        input  o_READ, o_ADDRESS, o_RD_DATA_REG, o_STATUS_REG
    );
endinterface

// File: rtl/rd_timeout_counter.sv
// -----------------------------------------------------------------------------
// rd_timeout_counter
// Counts cycles spent waiting for read data.
//   i_CLK, i_RST : clock, synchronous active-high reset
//   i_clear      : restart the count at zero
//   i_enable     : count this cycle (a waiting cycle with no data)
//   o_expired    : this is the LIMIT-th consecutive waiting cycle
// -----------------------------------------------------------------------------
module rd_timeout_counter #(
    parameter int LIMIT = 16
) (
    input  logic i_CLK,
    input  logic i_RST,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins over enable.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = {CW{1'b0}};
        end else if (i_enable) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expired = i_enable && (cnt_q == CW'(LIMIT - 1));
endmodule

// File: rtl/pixel_readback_encode.sv
// -----------------------------------------------------------------------------
// pixel_readback_encode
// Reads pairs of 12-bit pixels from pixel memory and packs each pair into a
// 32-bit readback register for the AXI side, one pair per acknowledge.
//   i_CLK, i_RST : clock, synchronous active-high reset
//   bus (master) : command register/strobe, pixel memory read port,
//                  readback data register, status register, data ack
// -----------------------------------------------------------------------------
module pixel_readback_encode
    import pixel_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int MAX_ADDR       = 76799
) (
    input  logic                    i_CLK,
    input  logic                    i_RST,
    pixel_readback_encode_if.master bus
);
    localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(MAX_ADDR);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic              odd_q, odd_d;
    logic [PIX_W-1:0]  even_q, even_d;
    logic [31:0]       rd_data_q, rd_data_d;
    logic              read_q, read_d;
    logic              dv_q, dv_d;
    logic              done_q, done_d;
    logic              tmo_q, tmo_d;
    logic              ovr_q, ovr_d;
    logic              bad_q, bad_d;

    logic              tmo_clear_s, tmo_en_s, tmo_expired_s;
    logic [ADDR_W-1:0] cmd_addr_s;
    logic [1:0]        cmd_op_s;
    logic [CNT_W-1:0]  cmd_cnt_s;
    logic [31:0]       status_s;

    assign cmd_addr_s = bus.i_CMD_REG[16:0];
    assign cmd_op_s   = bus.i_CMD_REG[18:17];
    assign cmd_cnt_s  = bus.i_CMD_REG[31:24];

    // The wait window restarts with every read request and only counts
    // waiting cycles without data, so data on the last allowed cycle wins.
    assign tmo_clear_s = (state_q == ISSUE);
    assign tmo_en_s    = (state_q == WAIT_DATA) && !bus.i_VALID_RD_DATA;

    rd_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
        .i_CLK     (i_CLK),
        .i_RST     (i_RST),
        .i_clear   (tmo_clear_s),
        .i_enable  (tmo_en_s),
        .o_expired (tmo_expired_s)
    );

    // Next-state and datapath logic. read_d mirrors "next state is ISSUE" so
    // the registered o_READ is high for exactly the ISSUE cycle.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        idx_d     = idx_q;
        odd_d     = odd_q;
        even_d    = even_q;
        rd_data_d = rd_data_q;
        read_d    = 1'b0;
        dv_d      = dv_q;
        done_d    = done_q;
        tmo_d     = tmo_q;
        ovr_d     = ovr_q;
        bad_d     = bad_q;

        if (bus.i_CMD_STROBE && (state_q != IDLE)) begin
            ovr_d = 1'b1;
        end else begin
            ovr_d = ovr_q;
        end

        case (state_q)
            IDLE: begin
                if (bus.i_CMD_STROBE) begin
                    if ((cmd_op_s == OP_READ) && (cmd_addr_s <= MAX_A)) begin
                        addr_d  = cmd_addr_s;
                        rem_d   = cmd_cnt_s;
                        idx_d   = {CNT_W{1'b0}};
                        odd_d   = 1'b0;
                        dv_d    = 1'b0;
                        done_d  = 1'b0;
                        tmo_d   = 1'b0;
                        ovr_d   = 1'b0;
                        bad_d   = 1'b0;
                        read_d  = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        bad_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (bus.i_VALID_RD_DATA) begin
                    addr_d = addr_wrap_inc(addr_q, MAX_A);
                    if (!odd_q) begin
                        even_d  = bus.i_DATA;
                        odd_d   = 1'b1;
                        read_d  = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        rd_data_d = {idx_q, bus.i_DATA, even_q};
                        odd_d     = 1'b0;
                        dv_d      = 1'b1;
                        state_d   = HOLD;
                    end
                end else if (tmo_expired_s) begin
                    // Any half-collected pair is dropped with the transfer.
                    tmo_d   = 1'b1;
                    odd_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_DATA;
                end
            end
            HOLD: begin
                if (bus.i_DATA_ACK) begin
                    dv_d = 1'b0;
                    if (rem_q == {CNT_W{1'b0}}) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        rem_d   = rem_q - {{(CNT_W-1){1'b0}}, 1'b1};
                        idx_d   = idx_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        read_d  = 1'b1;
                        state_d = ISSUE;
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q   <= IDLE;
            addr_q    <= {ADDR_W{1'b0}};
            rem_q     <= {CNT_W{1'b0}};
            idx_q     <= {CNT_W{1'b0}};
            odd_q     <= 1'b0;
            even_q    <= {PIX_W{1'b0}};
            rd_data_q <= 32'd0;
            read_q    <= 1'b0;
            dv_q      <= 1'b0;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
            ovr_q     <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            idx_q     <= idx_d;
            odd_q     <= odd_d;
            even_q    <= even_d;
            rd_data_q <= rd_data_d;
            read_q    <= read_d;
            dv_q      <= dv_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
            ovr_q     <= ovr_d;
            bad_q     <= bad_d;
        end
    end

    // Status word assembled from registered flags.
    always_comb begin
        status_s                               = 32'd0;
        status_s[ST_BUSY]                      = (state_q != IDLE);
        status_s[ST_DATA_VALID]                = dv_q;
        status_s[ST_DONE]                      = done_q;
        status_s[ST_TIMEOUT]                   = tmo_q;
        status_s[ST_OVERRUN]                   = ovr_q;
        status_s[ST_BAD_OP]                    = bad_q;
        status_s[ST_REM_LSB +: CNT_W]          = rem_q;
    end

    assign bus.o_READ        = read_q;
    assign bus.o_ADDRESS     = addr_q;
    assign bus.o_RD_DATA_REG = rd_data_q;
    assign bus.o_STATUS_REG  = status_s;
endmodule

// File: doc/pixel_readback_encode.md
PIXEL_READBACK_ENCODE -- requirements
Module: pixel_readback_encode

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning max cycles from o_READ to i_VALID_RD_DATA before abort.
REQ-002 SHALL have parameter MAX_ADDR, default 76799, meaning last valid pixel address (320x240 frame).
REQ-003 i_CLK  in  1  single clock; all logic on rising edge.
REQ-004 i_RST  in  1  reset, synchronous, active-high.
REQ-005 i_CMD_REG  in  32  command: [16:0] start address, [18:17] opcode (2'b10 = read), [31:24] pair count minus 1.
REQ-006 i_CMD_STROBE  in  1  one-cycle pulse; i_CMD_REG valid this cycle.
REQ-007 o_READ  out  1  one-cycle read request to pixel memory.
REQ-008 o_ADDRESS  out  17  pixel address, valid while o_READ=1.
REQ-009 i_DATA  in  12  pixel from memory.
REQ-010 i_VALID_RD_DATA  in  1  i_DATA valid this cycle.
REQ-011 o_RD_DATA_REG  out  32  [11:0] even pixel, [23:12] odd pixel, [31:24] pair index (low 8 bits).
REQ-012 o_STATUS_REG  out  32  [0] busy, [1] data_valid, [2] done, [3] timeout_err, [4] overrun, [5] bad_opcode, [15:8] pairs remaining.
REQ-013 i_DATA_ACK  in  1  AXI side consumed o_RD_DATA_REG.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT_DATA, HOLD.
REQ-015 IDLE: i_CMD_STROBE with opcode 2'b10 SHALL load address/count, clear done/timeout_err/overrun/bad_opcode, go ISSUE; o_READ asserted the next cycle (latency 1).
REQ-016 IDLE: i_CMD_STROBE with other opcode SHALL set bad_opcode, stay IDLE.
REQ-017 ISSUE: o_READ=1 for exactly one cycle with current address, then WAIT_DATA; timeout counter cleared.
REQ-018 WAIT_DATA: on i_VALID_RD_DATA, even-slot pixel captured to [11:0], address increments, back to ISSUE; odd-slot pixel captured to [23:12], go HOLD.
REQ-019 HOLD: data_valid=1, o_RD_DATA_REG stable until i_DATA_ACK; register updated cycle after odd pixel valid.
REQ-020 HOLD + i_DATA_ACK: data_valid cleared; pairs remaining decrements; if it was 0, set done and go IDLE, else pair index increments, go ISSUE.
REQ-021 i_DATA_ACK SHALL be ignored when data_valid=0.
REQ-022 Address at MAX_ADDR SHALL wrap to 0 on increment; start address > MAX_ADDR SHALL be treated as bad_opcode (command rejected).
REQ-023 WAIT_DATA reaching TIMEOUT_CYCLES without valid: set timeout_err, clear busy, go IDLE; partial pair discarded.
REQ-024 i_VALID_RD_DATA outside WAIT_DATA SHALL be ignored.
REQ-025 i_CMD_STROBE while busy SHALL be ignored and set sticky overrun.
REQ-026 busy=1 in every state except IDLE; pairs remaining field reflects count after each ACK.

Reset
REQ-027 i_RST SHALL force IDLE, o_READ=0, o_ADDRESS=0, o_RD_DATA_REG=0, o_STATUS_REG=0, counters 0, next cycle.
REQ-028 i_RST mid-operation SHALL abort without further o_READ; in-flight i_VALID_RD_DATA ignored.

Structure
REQ-029 Package pixel_bridge_pkg SHALL hold opcode constants, state enum, address/data widths (17/12), status bit positions.
REQ-030 One sub-module rd_timeout_counter (clear, enable, expired) SHALL implement the timeout.

Verification
REQ-031 Cmd 0x00040010 strobe -> o_READ addr 0x10 then 0x11; memory returns 0xABC, 0x123 -> o_RD_DATA_REG 0x00123ABC, data_valid=1, ACK -> done=1, busy=0.
REQ-032 Cmd 0x02040000 (3 pairs) -> six reads addr 0..5, three HOLD/ACK cycles, pair index 0,1,2, remaining 2,1,0.
REQ-033 Cmd 0x0105(MAX_ADDR=0x12BFF) i.e. start 0x12BFF, 2 pairs -> addresses 0x12BFF,0,1,2.
REQ-034 No i_VALID_RD_DATA for 16 cycles -> timeout_err=1, busy=0, no further o_READ.
REQ-035 Strobe while busy -> overrun=1, transfer unaffected; opcode 2'b11 in IDLE -> bad_opcode=1, no o_READ.
REQ-036 i_RST asserted in WAIT_DATA -> all outputs 0 next cycle; late i_VALID_RD_DATA produces no change.
